l2_mm_write_buffer: RTL and testbench

//  Posted write buffer between the L2 cache (upstream) and main memory (downstream).

---
 rtl/l2_mm_write_buffer_pkg.sv | 25 ++
 rtl/l2_mm_write_buffer_fifo.sv | 101 ++++++++++
 rtl/l2_mm_write_buffer.sv | 155 +++++++++++++++
 tb/tb_l2_mm_write_buffer.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_mm_write_buffer_pkg.sv
`default_nettype none
// ============================================================================
// l2_mm_write_buffer_pkg : shared types and defaults for the L2/MM write buffer
// Revision 1.0
// ============================================================================
package l2_mm_write_buffer_pkg;

  localparam int WB_DEPTH = 4;
  localparam int WB_DW    = 32;
  localparam int WB_AW    = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MM_WR = 2'd1,
    MM_RD = 2'd2
  } wb_state_t;

  typedef struct packed {
    logic             valid;
    logic [WB_AW-1:0] addr;
    logic [WB_DW-1:0] data;
  } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/l2_mm_write_buffer_fifo.sv
`default_nettype none
// ============================================================================
// l2_mm_write_buffer_fifo : circular posted-write store with youngest-match lookup
// Revision 1.0
// ============================================================================
module l2_mm_write_buffer_fifo
  import l2_mm_write_buffer_pkg::*;
#(
  parameter int N     = WB_DW,
  parameter int AW    = WB_AW,
  parameter int DEPTH = WB_DEPTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic [AW-1:0] push_addr_i,
  input  logic [N-1:0]  push_data_i,
  input  logic          pop_i,
  input  logic [AW-1:0] lookup_addr_i,
  output logic          hit_o,
  output logic [N-1:0]  hit_data_o,
  output logic [AW-1:0] head_addr_o,
  output logic [N-1:0]  head_data_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] addr;
    logic [N-1:0]  data;
  } entry_t;

  entry_t        ent_q [DEPTH];
  entry_t        ent_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push;
  logic          do_pop;

  assign full_o      = (count_q == C_FULL);
  assign empty_o     = (count_q == '0);
  assign do_pop      = pop_i && !empty_o;
  // A pop frees the head slot in the same cycle, so a push may land even when full.
  assign do_push     = push_i && (!full_o || do_pop);
  assign head_addr_o = ent_q[head_q].addr;
  assign head_data_o = ent_q[head_q].data;

  always_comb begin
    ent_d   = ent_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + CW'(do_push) - CW'(do_pop);
    if (do_pop) begin
      ent_d[head_q].valid = 1'b0;
      head_d              = head_q + PW'(1);
    end
    if (do_push) begin
      ent_d[tail_q] = '{valid: 1'b1, addr: push_addr_i, data: push_data_i};
      tail_d        = tail_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      ent_q   <= ent_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Walk oldest to youngest so the last match seen is the most recent write.
  always_comb begin
    logic [PW-1:0] idx;
    hit_o      = 1'b0;
    hit_data_o = '0;
    idx        = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if (ent_q[idx].valid && (ent_q[idx].addr == lookup_addr_i)) begin
        hit_o      = 1'b1;
        hit_data_o = ent_q[idx].data;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/l2_mm_write_buffer.sv
`default_nettype none
// ============================================================================
// l2_mm_write_buffer : posted write buffer between L2 and main memory, with
//                      read forwarding from buffered writes
// Revision 1.0
// ============================================================================
module l2_mm_write_buffer
  import l2_mm_write_buffer_pkg::*;
#(
  parameter int n     = WB_DW,
  parameter int AW    = WB_AW,
  parameter int DEPTH = WB_DEPTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          L2_write_request,
  input  logic          L2_read_request,
  input  logic [AW-1:0] L2_word_address,
  input  logic [n-1:0]  L2_wdata,
  output logic [n-1:0]  L2_rdata,
  output logic          L2_ready,
  output logic          mm_write_request,
  output logic          mm_read_request,
  output logic [AW-1:0] mm_word_address,
  output logic [n-1:0]  mm_wdata,
  input  logic [n-1:0]  mm_rdata,
  input  logic          mm_ready,
  output logic          buf_empty
);

  wb_state_t     state_q;
  logic          pending_q;
  logic [AW-1:0] rd_addr_q;
  logic          l2_ready_q;
  logic [n-1:0]  l2_rdata_q;
  logic          mm_wr_q;
  logic          mm_rd_q;
  logic [AW-1:0] mm_addr_q;
  logic [n-1:0]  mm_wdata_q;

  logic          fifo_full;
  logic          fifo_empty;
  logic          hit;
  logic [n-1:0]  hit_data;
  logic [AW-1:0] head_addr;
  logic [n-1:0]  head_data;
  logic          req_open;
  logic          rd_req;
  logic          wr_req;
  logic          pop;
  logic          push;

  // A request still high during its own ack cycle, or while its miss is outstanding, is not new.
  assign req_open = !l2_ready_q && !pending_q;
  assign rd_req   = L2_read_request && req_open;
  assign wr_req   = L2_write_request && !L2_read_request && req_open;
  assign pop      = (state_q == MM_WR) && mm_ready;
  assign push     = wr_req && (!fifo_full || pop);

  l2_mm_write_buffer_fifo #(
    .N     (n),
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk           (clk),
    .reset         (reset),
    .push_i        (push),
    .push_addr_i   (L2_word_address),
    .push_data_i   (L2_wdata),
    .pop_i         (pop),
    .lookup_addr_i (L2_word_address),
    .hit_o         (hit),
    .hit_data_o    (hit_data),
    .head_addr_o   (head_addr),
    .head_data_o   (head_data),
    .full_o        (fifo_full),
    .empty_o       (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      pending_q  <= 1'b0;
      rd_addr_q  <= '0;
      l2_ready_q <= 1'b0;
      l2_rdata_q <= '0;
      mm_wr_q    <= 1'b0;
      mm_rd_q    <= 1'b0;
      mm_addr_q  <= '0;
      mm_wdata_q <= '0;
    end else begin
      l2_ready_q <= 1'b0;
      if (rd_req) begin
        if (hit) begin
          l2_rdata_q <= hit_data;
          l2_ready_q <= 1'b1;
        end else begin
          pending_q <= 1'b1;
          rd_addr_q <= L2_word_address;
        end
      end else if (push) begin
        l2_ready_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          // Reads outrank draining; an in-flight drain is never preempted.
          if (pending_q) begin
            state_q   <= MM_RD;
            mm_rd_q   <= 1'b1;
            mm_addr_q <= rd_addr_q;
          end else if (!fifo_empty) begin
            state_q    <= MM_WR;
            mm_wr_q    <= 1'b1;
            mm_addr_q  <= head_addr;
            mm_wdata_q <= head_data;
          end
        end
        MM_WR: begin
          if (mm_ready) begin
            mm_wr_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        MM_RD: begin
          if (mm_ready) begin
            mm_rd_q    <= 1'b0;
            state_q    <= IDLE;
            l2_rdata_q <= mm_rdata;
            l2_ready_q <= 1'b1;
            pending_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          mm_wr_q <= 1'b0;
          mm_rd_q <= 1'b0;
        end
      endcase
    end
  end

  assign L2_ready         = l2_ready_q;
  assign L2_rdata         = l2_rdata_q;
  assign mm_write_request = mm_wr_q;
  assign mm_read_request  = mm_rd_q;
  assign mm_word_address  = mm_addr_q;
  assign mm_wdata         = mm_wdata_q;
  assign buf_empty        = fifo_empty && (state_q == IDLE) && !pending_q;

  a_single_l2_req : assert property (@(posedge clk) disable iff (!reset)
    !(L2_read_request && L2_write_request));

endmodule
`default_nettype wire

// File: tb/tb_l2_mm_write_buffer.sv
`default_nettype none
// ============================================================================
// tb_l2_mm_write_buffer : directed scenarios plus a randomized run against a
//                         memory-level reference model
// Revision 1.0
// ============================================================================
module tb_l2_mm_write_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        L2_write_request = 1'b0;
  logic        L2_read_request = 1'b0;
  logic [31:0] L2_word_address = '0;
  logic [31:0] L2_wdata = '0;
  logic [31:0] L2_rdata;
  logic        L2_ready;
  logic        mm_write_request;
  logic        mm_read_request;
  logic [31:0] mm_word_address;
  logic [31:0] mm_wdata;
  logic [31:0] mm_rdata;
  logic        mm_ready;
  logic        buf_empty;

  logic        man_rdy = 1'b0;
  logic [31:0] man_rdata = '0;
  logic        auto_mm = 1'b0;
  logic        auto_rdy = 1'b0;
  logic [31:0] auto_rdata = '0;
  int          total = 0;
  int          bad = 0;
  int          excl_viol = 0;
  int          lat_cnt = 0;
  logic [31:0] mm_mem [logic [31:0]];
  logic [31:0] golden [logic [31:0]];

  assign mm_ready = auto_mm ? auto_rdy : man_rdy;
  assign mm_rdata = auto_mm ? auto_rdata : man_rdata;

  always #5 clk = ~clk;

  l2_mm_write_buffer dut (
    .clk              (clk),
    .reset            (reset),
    .L2_write_request (L2_write_request),
    .L2_read_request  (L2_read_request),
    .L2_word_address  (L2_word_address),
    .L2_wdata         (L2_wdata),
    .L2_rdata         (L2_rdata),
    .L2_ready         (L2_ready),
    .mm_write_request (mm_write_request),
    .mm_read_request  (mm_read_request),
    .mm_word_address  (mm_word_address),
    .mm_wdata         (mm_wdata),
    .mm_rdata         (mm_rdata),
    .mm_ready         (mm_ready),
    .buf_empty        (buf_empty)
  );

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  // Main-memory slave with random latency, active only in the randomized run.
  always @(posedge clk) begin
    #1;
    if (auto_mm && !auto_rdy && (mm_write_request || mm_read_request)) begin
      if (lat_cnt == 0) begin
        auto_rdy = 1'b1;
        if (mm_write_request) mm_mem[mm_word_address] = mm_wdata;
        else auto_rdata = mm_mem.exists(mm_word_address) ? mm_mem[mm_word_address]
                                                         : init_val(mm_word_address);
        lat_cnt = $urandom_range(0, 4);
      end else begin
        lat_cnt = lat_cnt - 1;
      end
    end else begin
      auto_rdy = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (mm_write_request === 1'b1 && mm_read_request === 1'b1) excl_viol++;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got no completion want completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    L2_write_request = 1'b0;
    L2_read_request  = 1'b0;
    man_rdy          = 1'b0;
    reset            = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
  endtask

  task automatic pulse_mm();
    man_rdy = 1'b1;
    tick();
    man_rdy = 1'b0;
  endtask

  task automatic wait_mm(input bit rd, input int maxc, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < maxc; k++) begin
      if ((rd ? mm_read_request : mm_write_request) === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic l2_write(input logic [31:0] a, input logic [31:0] d, input int maxc,
                          output bit ok, output bit again);
    L2_word_address  = a;
    L2_wdata         = d;
    L2_write_request = 1'b1;
    ok               = 1'b0;
    for (int k = 0; k < maxc; k++) begin
      tick();
      if (L2_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    L2_write_request = 1'b0;
    tick();
    again = L2_ready;
  endtask

  task automatic l2_read(input logic [31:0] a, input int maxc, output bit ok,
                         output logic [31:0] data, output int lat, output bit again);
    L2_word_address = a;
    L2_read_request = 1'b1;
    ok              = 1'b0;
    data            = '0;
    lat             = 0;
    for (int k = 0; k < maxc; k++) begin
      tick();
      if (L2_ready === 1'b1) begin
        ok   = 1'b1;
        data = L2_rdata;
        lat  = k + 1;
        break;
      end
    end
    L2_read_request = 1'b0;
    tick();
    again = L2_ready;
  endtask

  task automatic test_reset();
    reset            = 1'b0;
    L2_write_request = 1'b1;
    L2_read_request  = 1'b1;
    L2_word_address  = 32'h1234;
    man_rdy          = 1'b1;
    repeat (2) tick();
    total++; if (L2_ready !== 1'b0) begin bad++; $display("FAIL rst_l2_ready: got %b want 0", L2_ready); end
    total++; if (L2_rdata !== 32'h0) begin bad++; $display("FAIL rst_l2_rdata: got %h want 0", L2_rdata); end
    total++; if (mm_write_request !== 1'b0) begin bad++; $display("FAIL rst_mm_wr: got %b want 0", mm_write_request); end
    total++; if (mm_read_request !== 1'b0) begin bad++; $display("FAIL rst_mm_rd: got %b want 0", mm_read_request); end
    total++; if (mm_word_address !== 32'h0) begin bad++; $display("FAIL rst_mm_addr: got %h want 0", mm_word_address); end
    total++; if (mm_wdata !== 32'h0) begin bad++; $display("FAIL rst_mm_wdata: got %h want 0", mm_wdata); end
    total++; if (buf_empty !== 1'b1) begin bad++; $display("FAIL rst_buf_empty: got %b want 1", buf_empty); end
    L2_write_request = 1'b0;
    L2_read_request  = 1'b0;
    man_rdy          = 1'b0;
    reset            = 1'b1;
    tick();
  endtask

  task automatic test_posted_write();
    bit ok;
    do_reset();
    L2_word_address  = 32'd12;
    L2_wdata         = 32'h55;
    L2_write_request = 1'b1;
    tick();
    total++; if (L2_ready !== 1'b1) begin bad++; $display("FAIL pw_ack: got %b want 1", L2_ready); end
    L2_write_request = 1'b0;
    tick();
    total++; if (L2_ready !== 1'b0) begin bad++; $display("FAIL pw_single_ack: got %b want 0", L2_ready); end
    wait_mm(1'b0, 5, ok);
    total++; if (!ok) begin bad++; $display("FAIL pw_mm_wr: got timeout want mm_write_request"); end
    total++; if (mm_word_address !== 32'd12 || mm_wdata !== 32'h55) begin
      bad++; $display("FAIL pw_mm_fields: got %h/%h want 0000000c/00000055", mm_word_address, mm_wdata);
    end
    repeat (9) tick();
    total++; if (mm_write_request !== 1'b1 || mm_word_address !== 32'd12) begin
      bad++; $display("FAIL pw_hold: got %b/%h want 1/0000000c", mm_write_request, mm_word_address);
    end
    total++; if (buf_empty !== 1'b0) begin bad++; $display("FAIL pw_busy: got %b want 0", buf_empty); end
    pulse_mm();
    total++; if (buf_empty !== 1'b1 || mm_write_request !== 1'b0) begin
      bad++; $display("FAIL pw_drained: got %b/%b want 1/0", buf_empty, mm_write_request);
    end
  endtask

  task automatic test_full_backpressure();
    bit ok, again;
    int acks;
    do_reset();
    for (int a = 1; a <= 4; a++) begin
      l2_write(32'(a), 32'h100 + 32'(a), 8, ok, again);
      total++; if (!ok) begin bad++; $display("FAIL full_ack%0d: got timeout want ack", a); end
    end
    L2_word_address  = 32'd5;
    L2_wdata         = 32'h105;
    L2_write_request = 1'b1;
    acks = 0;
    repeat (6) begin
      tick();
      if (L2_ready === 1'b1) acks++;
    end
    total++; if (acks != 0) begin bad++; $display("FAIL full_stall: got %0d acks want 0", acks); end
    total++; if (mm_write_request !== 1'b1 || mm_word_address !== 32'd1) begin
      bad++; $display("FAIL full_head: got %b/%h want 1/00000001", mm_write_request, mm_word_address);
    end
    pulse_mm();
    total++; if (L2_ready !== 1'b1) begin bad++; $display("FAIL full_push_with_pop: got %b want 1", L2_ready); end
    L2_write_request = 1'b0;
    tick();
    total++; if (L2_ready !== 1'b0) begin bad++; $display("FAIL full_single_ack: got %b want 0", L2_ready); end
    for (int a = 2; a <= 5; a++) begin
      wait_mm(1'b0, 6, ok);
      total++; if (!ok || mm_word_address !== 32'(a) || mm_wdata !== 32'h100 + 32'(a)) begin
        bad++; $display("FAIL full_drain%0d: got %b %h/%h want 1 %h/%h", a, ok, mm_word_address, mm_wdata,
                        32'(a), 32'h100 + 32'(a));
      end
      pulse_mm();
    end
    total++; if (buf_empty !== 1'b1) begin bad++; $display("FAIL full_empty: got %b want 1", buf_empty); end
  endtask

  task automatic test_forwarding();
    bit ok, again;
    logic [31:0] rd;
    int lat;
    do_reset();
    l2_write(32'd20, 32'd7, 8, ok, again);
    l2_write(32'd20, 32'd9, 8, ok, again);
    l2_read(32'd20, 8, ok, rd, lat, again);
    total++; if (!ok || rd !== 32'd9) begin bad++; $display("FAIL fwd_data: got %b %h want 1 00000009", ok, rd); end
    total++; if (lat != 1) begin bad++; $display("FAIL fwd_latency: got %0d want 1", lat); end
    total++; if (again !== 1'b0) begin bad++; $display("FAIL fwd_single_ack: got %b want 0", again); end
    total++; if (mm_read_request !== 1'b0) begin bad++; $display("FAIL fwd_no_mm_rd: got %b want 0", mm_read_request); end
    wait_mm(1'b0, 6, ok);
    total++; if (!ok || mm_wdata !== 32'd7) begin bad++; $display("FAIL fwd_drain0: got %b %h want 1 00000007", ok, mm_wdata); end
    pulse_mm();
    wait_mm(1'b0, 6, ok);
    total++; if (!ok || mm_wdata !== 32'd9) begin bad++; $display("FAIL fwd_drain1: got %b %h want 1 00000009", ok, mm_wdata); end
    pulse_mm();
    total++; if (buf_empty !== 1'b1) begin bad++; $display("FAIL fwd_empty: got %b want 1", buf_empty); end
  endtask

  task automatic test_read_miss_priority();
    bit ok, again;
    do_reset();
    l2_write(32'd30, 32'h11, 8, ok, again);
    l2_write(32'd31, 32'h22, 8, ok, again);
    wait_mm(1'b0, 6, ok);
    total++; if (!ok || mm_word_address !== 32'd30) begin
      bad++; $display("FAIL miss_first_drain: got %b %h want 1 0000001e", ok, mm_word_address);
    end
    L2_word_address = 32'd99;
    L2_read_request = 1'b1;
    repeat (3) tick();
    total++; if (mm_read_request !== 1'b0 || mm_write_request !== 1'b1 || mm_word_address !== 32'd30) begin
      bad++; $display("FAIL miss_drain_first: got rd=%b wr=%b %h want 0 1 0000001e",
                      mm_read_request, mm_write_request, mm_word_address);
    end
    total++; if (L2_ready !== 1'b0) begin bad++; $display("FAIL miss_no_early_ack: got %b want 0", L2_ready); end
    pulse_mm();
    wait_mm(1'b1, 6, ok);
    total++; if (!ok || mm_word_address !== 32'd99 || mm_write_request !== 1'b0) begin
      bad++; $display("FAIL miss_mm_rd: got %b %h wr=%b want 1 00000063 wr=0", ok, mm_word_address, mm_write_request);
    end
    man_rdata = 32'hABCD;
    pulse_mm();
    man_rdata = 32'h0;
    total++; if (L2_ready !== 1'b1 || L2_rdata !== 32'hABCD) begin
      bad++; $display("FAIL miss_data: got %b %h want 1 0000abcd", L2_ready, L2_rdata);
    end
    L2_read_request = 1'b0;
    tick();
    total++; if (L2_ready !== 1'b0) begin bad++; $display("FAIL miss_single_ack: got %b want 0", L2_ready); end
    wait_mm(1'b0, 6, ok);
    total++; if (!ok || mm_word_address !== 32'd31 || mm_wdata !== 32'h22) begin
      bad++; $display("FAIL miss_second_drain: got %b %h/%h want 1 0000001f/00000022", ok, mm_word_address, mm_wdata);
    end
    pulse_mm();
    total++; if (buf_empty !== 1'b1) begin bad++; $display("FAIL miss_empty: got %b want 1", buf_empty); end
  endtask

  task automatic test_reset_mid_drain();
    bit ok, again;
    do_reset();
    for (int a = 0; a < 3; a++) l2_write(32'd40 + 32'(a), 32'h40 + 32'(a), 8, ok, again);
    wait_mm(1'b0, 6, ok);
    total++; if (!ok) begin bad++; $display("FAIL mid_inflight: got timeout want mm_write_request"); end
    reset = 1'b0;
    tick();
    total++; if (buf_empty !== 1'b1 || mm_write_request !== 1'b0) begin
      bad++; $display("FAIL mid_cleared: got %b/%b want 1/0", buf_empty, mm_write_request);
    end
    reset   = 1'b1;
    man_rdy = 1'b1;
    tick();
    man_rdy = 1'b0;
    tick();
    total++; if (buf_empty !== 1'b1 || mm_write_request !== 1'b0 || mm_read_request !== 1'b0 || L2_ready !== 1'b0) begin
      bad++; $display("FAIL mid_late_ready: got %b/%b/%b/%b want 1/0/0/0",
                      buf_empty, mm_write_request, mm_read_request, L2_ready);
    end
    l2_write(32'd50, 32'h5, 8, ok, again);
    wait_mm(1'b0, 6, ok);
    total++; if (!ok || mm_word_address !== 32'd50) begin
      bad++; $display("FAIL mid_fresh_head: got %b %h want 1 00000032", ok, mm_word_address);
    end
    pulse_mm();
  endtask

  task automatic test_random();
    bit ok, again;
    logic [31:0] a, d, rd, exp;
    int lat, waitc;
    do_reset();
    golden.delete();
    mm_mem.delete();
    lat_cnt = 0;
    auto_mm = 1'b1;
    for (int op = 0; op < 120; op++) begin
      a = 32'($urandom_range(0, 7));
      d = $urandom();
      if ($urandom_range(0, 1) == 0) begin
        l2_write(a, d, 200, ok, again);
        total++; if (!ok) begin bad++; $display("FAIL rnd_wr_ack op%0d: got timeout want ack", op); end
        golden[a] = d;
      end else begin
        l2_read(a, 200, ok, rd, lat, again);
        exp = golden.exists(a) ? golden[a] : init_val(a);
        total++; if (!ok || rd !== exp) begin
          bad++; $display("FAIL rnd_rd op%0d addr %0d: got %b %h want 1 %h", op, a, ok, rd, exp);
        end
      end
      total++; if (again !== 1'b0) begin bad++; $display("FAIL rnd_single_ack op%0d: got %b want 0", op, again); end
      repeat ($urandom_range(0, 2)) tick();
    end
    waitc = 0;
    while (buf_empty !== 1'b1 && waitc < 500) begin
      tick();
      waitc++;
    end
    total++; if (buf_empty !== 1'b1) begin bad++; $display("FAIL rnd_drain: got %b want 1", buf_empty); end
    for (int i = 0; i < 8; i++) begin
      a = 32'(i);
      if (golden.exists(a)) begin
        rd = mm_mem.exists(a) ? mm_mem[a] : init_val(a);
        total++; if (rd !== golden[a]) begin
          bad++; $display("FAIL rnd_mem addr %0d: got %h want %h", i, rd, golden[a]);
        end
      end
    end
    total++; if (excl_viol != 0) begin bad++; $display("FAIL mm_exclusive: got %0d overlaps want 0", excl_viol); end
    auto_mm = 1'b0;
  endtask

  initial begin
    test_reset();
    test_posted_write();
    test_full_backpressure();
    test_forwarding();
    test_read_miss_priority();
    test_reset_mid_drain();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
